// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants and helpers for the RV32I pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int             XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // Instruction fetches are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Circular store of {pc, instr, filled}; entries are reserved at
//            request time and filled in order as memory responses return.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [XLEN-1:0]              i_push_pc,
    input  logic                         i_fill,
    input  logic [XLEN-1:0]              i_fill_data,
    input  logic                         i_pop,
    output logic                         o_head_valid,
    output logic [XLEN-1:0]              o_head_pc,
    output logic [XLEN-1:0]              o_head_instr,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_unfilled
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    r_pc    [DEPTH];
    logic [XLEN-1:0]    r_instr [DEPTH];
    logic [DEPTH-1:0]   r_filled;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_fill;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_nfilled;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_head    <= '0;
            r_fill    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_nfilled <= '0;
            r_filled  <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + c_PTR_W'(1);
            if (i_fill) r_fill <= r_fill + c_PTR_W'(1);
            if (i_pop)  r_head <= r_head + c_PTR_W'(1);

            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case ({i_fill, i_pop})
                2'b10:   r_nfilled <= r_nfilled + c_CNT_W'(1);
                2'b01:   r_nfilled <= r_nfilled - c_CNT_W'(1);
                default: r_nfilled <= r_nfilled;
            endcase

            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && r_tail == c_PTR_W'(i)) r_filled[i] <= 1'b0;
                if (i_fill && r_fill == c_PTR_W'(i)) r_filled[i] <= 1'b1;
                if (i_pop  && r_head == c_PTR_W'(i)) r_filled[i] <= 1'b0;
            end
        end
    end

    // Payload needs no reset: the filled bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (i_push) r_pc[r_tail]    <= i_push_pc;
        if (i_fill) r_instr[r_fill] <= i_fill_data;
    end

    assign o_head_valid = r_filled[r_head];
    assign o_head_pc    = r_pc[r_head];
    assign o_head_instr = r_instr[r_head];
    assign o_count      = r_count;
    assign o_unfilled   = r_count - r_nfilled;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch: PC, in-order imem requests, response
//            buffering and redirect flush with late-response dropping.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_DROP_W = $clog2(DEPTH) + 6;

    logic [XLEN-1:0]     r_pc;
    logic [c_DROP_W-1:0] r_drop_cnt;

    logic [c_DROP_W-1:0] w_drop_next;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W-1:0]  w_unfilled;
    logic                w_head_valid;
    logic [XLEN-1:0]     w_head_pc;
    logic [XLEN-1:0]     w_head_instr;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_drop_busy;
    logic                w_resp_drop;
    logic                w_resp_fill;
    logic                w_fill;
    logic                w_pop;

    assign w_req_valid = rst_n & ~redirect_valid & (w_count < c_CNT_W'(DEPTH));
    assign w_req_fire  = w_req_valid & imem_req_ready;
    assign w_drop_busy = (r_drop_cnt != '0);
    assign w_resp_drop = imem_resp_valid & w_drop_busy;
    assign w_resp_fill = imem_resp_valid & ~w_drop_busy & (w_unfilled != '0);
    assign w_fill      = w_resp_fill & ~redirect_valid;
    assign w_pop       = if_valid & id_ready & ~redirect_valid;

    // On redirect every reserved-but-unfilled slot becomes a response to
    // discard, minus the one whose data is arriving (and discarded) right now.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (w_resp_drop) w_drop_next = r_drop_cnt - c_DROP_W'(1);
        if (redirect_valid) begin
            w_drop_next = w_drop_next + c_DROP_W'(w_unfilled) - c_DROP_W'(w_resp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (redirect_valid) begin
                r_pc <= align_pc(redirect_pc);
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (redirect_valid),
        .i_push       (w_req_fire),
        .i_push_pc    (r_pc),
        .i_fill       (w_fill),
        .i_fill_data  (imem_resp_data),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_valid       = rst_n & w_head_valid;
    assign if_instruction = if_valid ? w_head_instr : NOP_INSTR;
    assign if_pc          = if_valid ? w_head_pc : '0;
    assign if_pc_plus4    = if_pc + PC_STEP;

    // A response must either be owed to a flushed request or fill a slot.
    a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (w_drop_busy || (w_unfilled != '0)))
        else $error("fetch_stage: imem response with nothing outstanding");

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: vector table, directed
//            corner sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W0    = 32'h007302b3;
    localparam logic [31:0] W4    = 32'h00a48433;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return W0;
            32'h4:   return W4;
            default: return {addr[15:0] ^ 16'hC0DE, addr[15:2], 2'b11};
        endcase
    endfunction

    task automatic step(input logic rn, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [31:0] rpc, input logic idr);
        @(negedge clk);
        rst_n = rn; imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
        redirect_valid = redir; redirect_pc = rpc; id_ready = idr;
        #1;
    endtask

    // ---------------- reference model: ordered queue of fetch slots --------
    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    ent_t        mq[$];
    int          mdrop = 0;
    logic [31:0] mpc = '0;
    bit          model_on = 1'b0;

    function automatic bit m_head_ok();
        return (mq.size() > 0) && mq[0].filled;
    endfunction

    task automatic model_check();
        bit          ev;
        bit          erv;
        logic [31:0] epc;
        ev  = rst_n && m_head_ok();
        erv = rst_n && !redirect_valid && (mq.size() < DEPTH);
        epc = ev ? mq[0].pc : 32'h0;
        check("model_req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
        if (erv) check("model_req_addr", imem_req_addr, mpc);
        check("model_if_valid", {31'b0, if_valid}, {31'b0, ev});
        check("model_if_instr", if_instruction, ev ? mq[0].instr : NOP);
        check("model_if_pc", if_pc, epc);
        check("model_if_pc_plus4", if_pc_plus4, epc + 32'd4);
    endtask

    task automatic model_update();
        bit   pop;
        bit   push;
        int   unf;
        int   k;
        ent_t e;
        if (!rst_n) begin
            mq.delete(); mdrop = 0; mpc = 32'h0; model_on = 1'b1;
        end else if (model_on) begin
            pop  = m_head_ok() && id_ready && !redirect_valid;
            push = !redirect_valid && (mq.size() < DEPTH) && imem_req_ready;
            if (redirect_valid) begin
                unf = 0;
                foreach (mq[i]) if (!mq[i].filled) unf++;
                if (imem_resp_valid) begin
                    if (mdrop > 0) mdrop--;
                    else if (unf > 0) unf--;
                end
                mdrop += unf;
                mq.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (imem_resp_valid) begin
                    if (mdrop > 0) mdrop--;
                    else begin
                        k = -1;
                        foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
                        if (k >= 0) begin
                            e = mq[k]; e.instr = imem_resp_data; e.filled = 1'b1; mq[k] = e;
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc = mpc; e.instr = '0; e.filled = 1'b0;
                    mq.push_back(e);
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (model_on) model_check();
            @(posedge clk);
            model_update();
        end
    end

    // ---------------- vector table ----------------------------------------
    typedef struct {
        logic rn; logic rdy; logic rv; logic [31:0] rd; logic idr;
        logic e_rv; logic [31:0] e_addr; logic e_ifv; logic [31:0] e_instr; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl [7];

    logic [31:0] pend[$];
    int          n_req;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,  1'b0, NOP,           32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,  1'b0, NOP,           32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, W0,             1'b1, 1'b1, 32'h4,  1'b0, NOP,           32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, W4,             1'b1, 1'b0, 32'h0,  1'b1, W0,            32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8,  1'b1, W4,            32'h4};
        tbl[5] = '{1'b1, 1'b1, 1'b1, mem_word(32'h8), 1'b1, 1'b1, 32'hC, 1'b0, NOP,           32'h0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, mem_word(32'hC), 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h8), 32'h8};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rn, tbl[i].rdy, tbl[i].rv, tbl[i].rd, 1'b0, 32'h0, tbl[i].idr);
            check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].e_ifv});
            check($sformatf("vec%0d_if_instr", i), if_instruction, tbl[i].e_instr);
            check($sformatf("vec%0d_if_pc", i), if_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_if_pc_plus4", i), if_pc_plus4, tbl[i].e_pc + 32'd4);
        end

        // Stall: ID holds off, fetch stops once DEPTH slots are taken.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        n_req = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); n_req += int'(imem_req_valid && imem_req_ready);
        step(1'b1, 1'b1, 1'b1, W0,    1'b0, 32'h0, 1'b0); n_req += int'(imem_req_valid && imem_req_ready);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, (i == 0), W4, 1'b0, 32'h0, 1'b0);
            n_req += int'(imem_req_valid && imem_req_ready);
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
            check("stall_if_instr", if_instruction, W0);
            check("stall_if_pc", if_pc, 32'h0);
        end
        check("stall_req_count", n_req, DEPTH);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("stall_release_pc0", if_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("stall_resume_addr", imem_req_addr, 32'h8);
        check("stall_resume_valid", {31'b0, imem_req_valid}, 32'h1);
        check("stall_release_pc4", if_pc, 32'h4);

        // Redirect with two requests in flight: both late responses dropped.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        check("redir_req_blocked", {31'b0, imem_req_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b1, W0, 1'b0, 32'h0, 1'b1);
        check("redir_new_addr", imem_req_addr, 32'h100);
        check("redir_drop0_ifv", {31'b0, if_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b1, W4, 1'b0, 32'h0, 1'b1);
        check("redir_drop1_ifv", {31'b0, if_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b1, mem_word(32'h100), 1'b0, 32'h0, 1'b1);
        check("redir_fill_ifv", {31'b0, if_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("redir_first_pc", if_pc, 32'h100);
        check("redir_first_instr", if_instruction, mem_word(32'h100));

        // Redirect coinciding with a response and a would-be pop.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, W0,    1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, W4,    1'b1, 32'h200, 1'b1);
        check("rrp_req_blocked", {31'b0, imem_req_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rrp_flushed_ifv", {31'b0, if_valid}, 32'h0);
        check("rrp_new_addr", imem_req_addr, 32'h200);
        step(1'b1, 1'b0, 1'b1, mem_word(32'h200), 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rrp_first_pc", if_pc, 32'h200);
        check("rrp_first_instr", if_instruction, mem_word(32'h200));

        // Target alignment and PC wrap.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("align_addr", imem_req_addr, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr_zero", imem_req_addr, 32'h0);
        step(1'b1, 1'b0, 1'b1, mem_word(32'hFFFF_FFFC), 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, W0, 1'b0, 32'h0, 1'b1);
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", if_pc_plus4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("wrap_next_pc", if_pc, 32'h0);

        // Reset mid-stream with two buffered entries.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, W0,    1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, W4,    1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("mrst_before_ifv", {31'b0, if_valid}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("mrst_ifv", {31'b0, if_valid}, 32'h0);
        check("mrst_instr", if_instruction, NOP);
        check("mrst_pc", if_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("mrst_after_ifv", {31'b0, if_valid}, 32'h0);
        check("mrst_after_addr", imem_req_addr, 32'h0);
        check("mrst_after_req", {31'b0, imem_req_valid}, 32'h1);

        // Random traffic with an in-order, variable-latency memory.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        rn, rdy, rv, redir, idr, fire;
            logic [31:0] rd, rpc, faddr;
            rn    = ($urandom_range(0, 99) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = $urandom;
            idr   = ($urandom_range(0, 2) != 0);
            rv    = rn && (pend.size() > 0) && ($urandom_range(0, 2) != 0);
            rd    = rv ? mem_word(pend[0]) : $urandom;
            step(rn, rdy, rv, rd, redir, rpc, idr);
            fire  = imem_req_valid && imem_req_ready;
            faddr = imem_req_addr;
            @(posedge clk);
            if (!rn) pend.delete();
            else begin
                if (rv) void'(pend.pop_front());
                if (fire) pend.push_back(faddr);
            end
        end

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
